branch_resolve_queue: RTL
=========================

# branch_resolve_queue

Tracks every conditional branch the fetch stage predicts and checks each prediction when execute resolves it. Fetch pushes one entry per predicted branch: PC, predicted direction and predicted target. Execute resolves entries strictly in program order. On a mispredict, the block issues a registered redirect and flush, discards all younger in-flight predictions, and updates branch and mispredict statistics. It sits between the fetch-stage training outputs and the execute-stage branch comparator.

## Interface
- DEPTH, 4: number of in-flight predicted branches (power of two, ≥2)
- XLEN, 32: data/target width
- PC_WIDTH, 32: PC width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- F_train_vaild_i  in  1  fetch pushes a predicted conditional branch this cycle
- F_train_predict_i  in  1  predicted direction (1 = taken)
- F_PC_i  in  PC_WIDTH  PC of the branch
- F_target_i  in  XLEN  predicted taken target (PC + imm)
- F_full_o  out  1  queue full; fetch must stall pushes
- E_resolve_vaild_i  in  1  execute resolves the oldest outstanding branch
- E_taken_i  in  1  actual outcome (1 = taken)
- redirect_vaild_o  out  1  one-cycle redirect pulse
- redirect_pc_o  out  XLEN  correct next PC
- flush_o  out  1  flush younger pipeline state (equals redirect_vaild_o)
- count_o  out  $clog2(DEPTH)+1  entries currently held
- branch_cnt_o  out  32  branches resolved
- mispredict_cnt_o  out  32  mispredicts detected
- err_o  out  1  sticky: resolve with empty queue, or push while full without pop

## Operation
- Storage: circular buffer of DEPTH entries {pc, predict, target}. Read pointer and write pointer are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
- Push is accepted when F_train_vaild_i=1 and either count<DEPTH or a resolve happens the same cycle.
- Push while full with no resolve: the push is dropped and err_o is set.
- Resolve is accepted when E_resolve_vaild_i=1 and count>0. It pops the head entry and increments branch_cnt_o.
- Resolve with count=0 is ignored and sets err_o.
- Mispredict is defined as head.predict != E_taken_i.
  - mispredict_cnt_o increments.
  - Next cycle: redirect_vaild_o=flush_o=1.
  - redirect_pc_o = E_taken_i ? head.target : head.pc + 4. The addition is done in XLEN bits and wraps mod 2^XLEN.
  - All remaining entries are discarded and count becomes 0. Any push in the same cycle is also discarded, since it is wrong-path.
- Correct prediction: no redirect; redirect_pc_o holds its previous value.
- Simultaneous push and correct resolve: count is unchanged and both pointers advance.
- Counters wrap from 0xFFFFFFFF to 0.
- err_o clears only on rst.
- Reset values:
  - count_o = 0 and F_full_o = 0.
  - redirect_vaild_o = flush_o = 0 and redirect_pc_o = 0.
  - Both statistics counters = 0, err_o = 0, pointers = 0.
- Reset mid-operation empties the queue immediately (asynchronous) and drops any pending redirect.

## Timing
- All outputs are registered or decoded directly from registers; there are no combinational paths from inputs to outputs.
- F_full_o = (count == DEPTH), decoded from the count register. It updates the cycle after the push that fills the queue.
- An entry pushed in cycle N is resolvable from cycle N+1. There is no same-cycle push-to-resolve bypass.
- Redirect latency: a resolve in cycle N produces redirect_vaild_o in cycle N+1, high for exactly one cycle. Back-to-back redirects are impossible because the queue is empty afterwards.
- A push in cycle N+1, during the redirect pulse, is accepted and becomes the first right-path entry.
- Counters and count_o reflect cycle-N events in cycle N+1.

## Test plan
- Reset, then idle: every output is 0 and F_full_o=0.
  - Assert rst mid-stream with 3 entries queued: count_o goes to 0 immediately and no redirect follows.
- Push 4 branches (PC 0x100/0x200/0x300/0x400, predict=1, target=PC+0x40), then a 5th push with no resolve:
  - F_full_o=1 after the 4th push.
  - The 5th push is dropped and err_o=1.
- Push PC 0x100, predict=1, target 0x140; resolve with E_taken_i=1: no redirect, branch_cnt_o=1, mispredict_cnt_o=0.
- Queue 3 entries, head PC 0x100 with predict=1; resolve with E_taken_i=0 while pushing a new entry:
  - Next cycle redirect_vaild_o=flush_o=1 and redirect_pc_o=0x104.
  - count_o=0 and the same-cycle push is discarded.
- Head PC 0x200, predict=0, target 0x180; resolve with taken=1: redirect_pc_o=0x180 and mispredict_cnt_o increments.
- Full queue plus simultaneous push and correct resolve for 10 cycles: count_o stays at 4, pointers wrap, and entries resolve in FIFO order.
  - Resolving an empty queue sets err_o.

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// Fetch-training / execute-resolve / redirect signal bundle for branch_resolve_queue.
// The master side drives the fetch and execute inputs; the slave side is the queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                       F_train_vaild_i;
    logic                       F_train_predict_i;
    logic [PC_WIDTH-1:0]        F_PC_i;
    logic [XLEN-1:0]            F_target_i;
    logic                       F_full_o;
    logic                       E_resolve_vaild_i;
    logic                       E_taken_i;
    logic                       redirect_vaild_o;
    logic [XLEN-1:0]            redirect_pc_o;
    logic                       flush_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic [31:0]                branch_cnt_o;
    logic [31:0]                mispredict_cnt_o;
    logic                       err_o;

    modport master (
        output F_train_vaild_i, F_train_predict_i, F_PC_i, F_target_i,
        output E_resolve_vaild_i, E_taken_i,
        input  F_full_o, redirect_vaild_o, redirect_pc_o, flush_o,
        input  count_o, branch_cnt_o, mispredict_cnt_o, err_o
    );

    modport slave (
        input  F_train_vaild_i, F_train_predict_i, F_PC_i, F_target_i,
        input  E_resolve_vaild_i, E_taken_i,
        output F_full_o, redirect_vaild_o, redirect_pc_o, flush_o,
        output count_o, branch_cnt_o, mispredict_cnt_o, err_o
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches; checks each prediction at resolve
// and issues a registered redirect/flush on a mispredict.
module branch_resolve_queue #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_resolve_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

    logic [PC_WIDTH-1:0] r_pc   [DEPTH];
    logic                r_pred [DEPTH];
    logic [XLEN-1:0]     r_tgt  [DEPTH];

    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_branch_cnt;
    logic [31:0]     r_mis_cnt;
    logic            r_err;

    logic            w_res_ok;
    logic            w_push_ok;
    logic            w_mis;
    logic [XLEN-1:0] w_fix_pc;

    always_comb begin
        w_res_ok  = bus.E_resolve_vaild_i && (r_count != '0);
        // A same-cycle pop frees a slot, so a full queue can still accept a push.
        w_push_ok = bus.F_train_vaild_i && ((r_count != LP_FULL) || w_res_ok);
        w_mis     = w_res_ok && (r_pred[r_rd_ptr] != bus.E_taken_i);
        w_fix_pc  = bus.E_taken_i ? r_tgt[r_rd_ptr]
                                  : XLEN'(r_pc[r_rd_ptr]) + XLEN'(4);
    end

    // Entry storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok && !w_mis) begin
            r_pc[r_wr_ptr]   <= bus.F_PC_i;
            r_pred[r_wr_ptr] <= bus.F_train_predict_i;
            r_tgt[r_wr_ptr]  <= bus.F_target_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mis_cnt     <= '0;
            r_err         <= 1'b0;
        end else begin
            r_redirect <= w_mis;
            if (w_mis) begin
                // Discard every younger entry and the wrong-path push.
                r_rd_ptr      <= r_wr_ptr;
                r_count       <= '0;
                r_redirect_pc <= w_fix_pc;
                r_mis_cnt     <= r_mis_cnt + 32'd1;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_res_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push_ok, w_res_ok})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
            if (w_res_ok) r_branch_cnt <= r_branch_cnt + 32'd1;
            if ((bus.F_train_vaild_i && !w_push_ok) ||
                (bus.E_resolve_vaild_i && !w_res_ok))
                r_err <= 1'b1;
        end
    end

    assign bus.F_full_o         = (r_count == LP_FULL);
    assign bus.count_o          = r_count;
    assign bus.redirect_vaild_o = r_redirect;
    assign bus.flush_o          = r_redirect;
    assign bus.redirect_pc_o    = r_redirect_pc;
    assign bus.branch_cnt_o     = r_branch_cnt;
    assign bus.mispredict_cnt_o = r_mis_cnt;
    assign bus.err_o            = r_err;
endmodule
